// File: rtl/uart_rx_axis.sv
// uart_rx_axis: 16x-oversampled 8N1 UART receiver
// feeding an AXI4-Stream master through a FWFT byte FIFO.
module uart_rx_axis #(
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     en_16x_baud,
    input  logic                     RX,
    output logic [7:0]               m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     framing_err,
    output logic                     overrun,
    output logic [FIFO_DEPTH_LOG2:0] fifo_count
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [FIFO_DEPTH_LOG2:0] CNT_FULL =
        (FIFO_DEPTH_LOG2+1)'(DEPTH);
    localparam logic [FIFO_DEPTH_LOG2:0] CNT_ONE =
        (FIFO_DEPTH_LOG2+1)'(1);
    localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE =
        FIFO_DEPTH_LOG2'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    logic [1:0]                   rst_pipe;
    logic                         rst_n;
    logic [SYNC_STAGES-1:0]       sync_q;
    logic                         rxs;
    state_t                       state_q, state_d;
    logic [3:0]                   cnt_q, cnt_d;
    logic [2:0]                   idx_q, idx_d;
    logic [7:0]                   sh_q, sh_d;
    logic                         push_req;
    logic                         ferr_d;
    logic [7:0]                   mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0]   wr_ptr, rd_ptr, rd_d;
    logic [FIFO_DEPTH_LOG2:0]     count_d;
    logic                         pop, full, wr_en, ovr_d;

    // Reset: asserts immediately, releases on a clock edge
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) rst_pipe <= '0;
        else          rst_pipe <= {rst_pipe[0], 1'b1};
    end

    assign rst_n = rst_pipe[1];

    // Metastability chain on the asynchronous line, idle high
    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) sync_q <= '1;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], RX};
    end

    assign rxs = sync_q[SYNC_STAGES-1];

    // Receiver state and bit-timing registers
    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
        end
    end

    // Frame decoding; every step advances only on a baud tick
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        sh_d     = sh_q;
        push_req = 1'b0;
        ferr_d   = 1'b0;
        if (en_16x_baud) begin
            unique case (state_q)
                IDLE: begin
                    if (!rxs) begin
                        state_d = START;
                        cnt_d   = '0;
                    end
                end
                START: begin
                    if (cnt_q == 4'd7) begin
                        if (!rxs) begin
                            state_d = DATA;
                            cnt_d   = '0;
                            idx_d   = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                DATA: begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        sh_d  = {rxs, sh_q[7:1]};
                        idx_d = idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            state_d = STOP;
                            cnt_d   = '0;
                        end
                    end
                end
                STOP: begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        if (rxs) begin
                            push_req = 1'b1;
                            state_d  = IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = BRK;
                        end
                    end
                end
                BRK: begin
                    if (rxs) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign m_axis_tvalid = (fifo_count != '0);
    assign pop   = m_axis_tvalid && m_axis_tready;
    assign full  = (fifo_count == CNT_FULL);
    assign wr_en = push_req && (!full || pop);
    assign ovr_d = push_req && full && !pop;
    assign rd_d  = pop ? rd_ptr + PTR_ONE : rd_ptr;

    // Next occupancy from the push/pop pair
    always_comb begin
        count_d = fifo_count;
        if (wr_en && !pop)      count_d = fifo_count + CNT_ONE;
        else if (!wr_en && pop) count_d = fifo_count - CNT_ONE;
    end

    // FIFO storage; contents need no reset
    always_ff @(posedge aclk) begin
        if (wr_en) mem[wr_ptr] <= sh_q;
    end

    // Pointers, occupancy, registered head and error pulses
    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            m_axis_tdata <= '0;
            framing_err  <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            rd_ptr      <= rd_d;
            fifo_count  <= count_d;
            framing_err <= ferr_d;
            overrun     <= ovr_d;
            if (count_d != '0) begin
                if (fifo_count == (pop ? CNT_ONE : '0))
                    m_axis_tdata <= sh_q;
                else
                    m_axis_tdata <= mem[rd_d];
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_axis.sv
// tb_uart_rx_axis: directed frames with a scoreboard queue
// checked by an independent AXI-Stream beat monitor.
module tb_uart_rx_axis;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic       en_16x_baud = 1'b1;
    logic       RX = 1'b1;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready = 1'b0;
    logic       framing_err;
    logic       overrun;
    logic [4:0] fifo_count;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned rise_cyc = 0;
    int unsigned c0;
    int          ferr_cnt = 0;
    int          ovr_cnt = 0;
    int          f0, o0;
    logic        prev_valid = 1'b0;
    logic [7:0]  exp_q[$];
    logic [7:0]  mon_exp;

    uart_rx_axis dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .en_16x_baud   (en_16x_baud),
        .RX            (RX),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .framing_err   (framing_err),
        .overrun       (overrun),
        .fifo_count    (fifo_count)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    // Beat monitor and pulse counters, sampled mid-cycle
    always @(negedge aclk) begin
        if (framing_err) ferr_cnt++;
        if (overrun) ovr_cnt++;
        if (m_axis_tvalid && !prev_valid) rise_cyc = cyc;
        prev_valid = m_axis_tvalid;
        if (m_axis_tvalid && m_axis_tready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL beat got %02h want none", m_axis_tdata);
            end else begin
                mon_exp = exp_q.pop_front();
                if (m_axis_tdata !== mon_exp) begin
                    errors++;
                    $display("FAIL beat got %02h want %02h",
                             m_axis_tdata, mon_exp);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        RX = v;
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v,
                              input int stop_len);
        hold(1'b0, 16);
        for (int i = 0; i < 8; i++) hold(b[i], 16);
        hold(stop_v, stop_len);
        hold(1'b1, 16);
    endtask

    task automatic send_good(input logic [7:0] b);
        exp_q.push_back(b);
        send_frame(b, 1'b1, 16);
    endtask

    task automatic wait_drain(input string name, input int maxc);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < maxc) begin
            @(negedge aclk);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge aclk);
        #1;
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_ferr", framing_err, 0);
        check("rst_ovr", overrun, 0);
        check("rst_count", fifo_count, 0);
        aresetn = 1'b1;
        repeat (5) @(posedge aclk);
        #1;

        // Single byte and its latency from start edge
        m_axis_tready = 1'b1;
        c0 = cyc;
        send_good(8'hA5);
        wait_drain("a5_drain", 50);
        check("a5_latency", rise_cyc - c0, 155);

        // Short low glitch is rejected silently
        f0 = ferr_cnt;
        hold(1'b0, 4);
        hold(1'b1, 40);
        check("glitch_ferr", ferr_cnt, f0);
        check("glitch_valid", m_axis_tvalid, 0);

        // Bad stop bit with long break, then a good byte
        send_frame(8'h3C, 1'b0, 40);
        check("break_ferr", ferr_cnt, f0 + 1);
        check("break_valid", m_axis_tvalid, 0);
        send_good(8'h55);
        wait_drain("55_drain", 50);

        // Overflow: 17 bytes into 16 entries
        m_axis_tready = 1'b0;
        o0 = ovr_cnt;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1, 16);
        end
        check("full_count", fifo_count, 16);
        check("full_ovr", ovr_cnt, o0 + 1);
        check("full_head", m_axis_tdata, 8'h00);
        m_axis_tready = 1'b1;
        wait_drain("ovf_drain", 100);
        check("ovf_empty", fifo_count, 0);

        // Full FIFO with pop on the push cycle
        m_axis_tready = 1'b0;
        for (int i = 0; i < 16; i++) send_good(8'h20 + 8'(i));
        exp_q.push_back(8'h7E);
        fork
            send_frame(8'h7E, 1'b1, 16);
            begin
                repeat (154) @(posedge aclk);
                #1 m_axis_tready = 1'b1;
                @(posedge aclk);
                #1 m_axis_tready = 1'b0;
            end
        join
        check("pp_count", fifo_count, 16);
        check("pp_ovr", ovr_cnt, o0 + 1);
        check("pp_head", m_axis_tdata, 8'h21);
        m_axis_tready = 1'b1;
        wait_drain("pp_drain", 100);

        // Reset mid-frame flushes buffered and partial bytes
        m_axis_tready = 1'b0;
        send_frame(8'h11, 1'b1, 16);
        check("pre_rst_count", fifo_count, 1);
        hold(1'b0, 16);
        hold(1'b1, 16);
        hold(1'b0, 16);
        aresetn = 1'b0;
        RX = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        check("mid_rst_tvalid", m_axis_tvalid, 0);
        check("mid_rst_tdata", m_axis_tdata, 0);
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_ferr", framing_err, 0);
        check("mid_rst_ovr", overrun, 0);
        aresetn = 1'b1;
        repeat (5) @(posedge aclk);
        #1;
        m_axis_tready = 1'b1;
        send_good(8'h42);
        wait_drain("42_drain", 50);
        repeat (20) @(posedge aclk);
        #1;
        check("end_empty", fifo_count, 0);
        check("ferr_total", ferr_cnt, 1);
        check("ovr_total", ovr_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
